// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch run/lap/stop controller.
package stopwatch_pkg;

  // Controller states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam int unsigned STATE_W = 2;

  // True in the states where the counter is allowed to advance.
  function automatic logic is_counting(state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the board side (keys, divider tick, counter) and
// the stopwatch controller.
interface stopwatch_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  import stopwatch_pkg::*;

  logic [1:0]         KEY;       // raw active-low buttons: [0] start/stop, [1] lap/clear
  logic               tick;      // one-cycle strobe from the clock divider
  logic [WIDTH-1:0]   count_in;  // live counter value
  logic               en;        // counter increment enable
  logic               clr;       // one-cycle synchronous counter clear
  logic [WIDTH-1:0]   disp;      // value for the BCD converter
  logic [STATE_W-1:0] state;     // current controller state

  // Board side: drives keys, tick and the counter value.
  modport master (
    output KEY, tick, count_in,
    input  en, clr, disp, state
  );

  // Controller side.
  modport slave (
    input  KEY, tick, count_in,
    output en, clr, disp, state
  );

endinterface

// File: rtl/stopwatch_ctrl_key_debounce.sv
// One push-button front end: 2-flop synchroniser, debounce counter and a
// registered one-cycle press pulse on a debounced 1->0 transition.
// Press pulses are held off after reset until the key has been seen
// released for a full debounce window, so a key held through reset
// cannot produce a pulse when reset is released.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d1;
  logic [CNT_W-1:0] db_cnt;
  logic             armed;
  logic [CNT_W-1:0] arm_cnt;

  // Synchroniser; both flops reset to the released level.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Debounced level flips after DEBOUNCE_CYCLES consecutive differing samples;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level  <= 1'b1;
      db_cnt <= '0;
    end else if (sync2 != level) begin
      if (db_cnt == CNT_LAST) begin
        level  <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Arm the press output once the key has been stably released for a
  // full debounce window after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else if (!armed) begin
      if (sync2 && level) begin
        if (arm_cnt == CNT_LAST) begin
          armed <= 1'b1;
        end else begin
          arm_cnt <= arm_cnt + 1'b1;
        end
      end else begin
        arm_cnt <= '0;
      end
    end
  end

  // Registered press pulse on a debounced 1->0 transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d1 <= 1'b1;
      press    <= 1'b0;
    end else begin
      level_d1 <= level;
      press    <= armed & level_d1 & ~level;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/lap/stop controller: debounces the two keys, drives the counter
// enable/clear with saturation at all-ones, and freezes the display value
// while a lap is held.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned WIDTH           = 16
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  stopwatch_ctrl_if.slave  sw
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state_q;
  state_t           state_d;
  logic             p0;
  logic             p1;
  logic             at_max;
  logic             counting;
  logic             sat;
  logic             clr_d;
  logic             clr_q;
  logic [WIDTH-1:0] disp_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_run (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .key_n (sw.KEY[0]),
    .press (p0)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_lap (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .key_n (sw.KEY[1]),
    .press (p1)
  );

  assign counting = is_counting(state_q);
  assign at_max   = (sw.count_in == ALL_ONES);
  // A tick at all-ones stops the watch instead of wrapping the counter.
  assign sat      = sw.tick & counting & at_max;
  assign sw.en    = sw.tick & counting & ~at_max;

  // Next-state logic; start/stop has priority over lap/clear.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0) state_d = RUN;
      end
      RUN: begin
        if (p0 || sat) state_d = STOP;
        else if (p1)   state_d = LAP;
      end
      LAP: begin
        if (p0 || sat) state_d = STOP;
        else if (p1)   state_d = RUN;
      end
      STOP: begin
        if (p0) begin
          state_d = RUN;
        end else if (p1) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and one-cycle clear, asserted in the first IDLE cycle.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Display register: follows the counter except while in LAP. Entering LAP
  // from RUN loads the count of that edge, which is then held.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      disp_q <= '0;
    end else if (state_q != LAP) begin
      disp_q <= sw.count_in;
    end
  end

  assign sw.clr   = clr_q;
  assign sw.disp  = disp_q;
  assign sw.state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a short debounce window.
module tb_stopwatch_ctrl;

  localparam int N = 4;
  localparam int W = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAP  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_ctrl_if #(.WIDTH(W)) sw ();

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(N), .WIDTH(W)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .sw       (sw)
  );

  int total = 0;
  int bad   = 0;

  // Bench-driven inputs
  logic [1:0]   key_v  = 2'b11;
  logic         tick_v = 1'b0;
  logic [W-1:0] cnt_v  = '0;

  // Reference model: key sample pipeline plus run-length debounce and FSM
  logic [1:0]   key_hist[$];
  logic [1:0]   m_st;
  logic [W-1:0] m_disp;
  logic         m_clr;
  logic [1:0]   m_p;
  bit           m_lvl[2];
  bit           m_armed[2];
  bit           m_fell[2];
  int           m_run[2];
  int           m_diff[2];

  // Observation counters for multi-cycle sequences
  int           clr_seen;
  int           clr_en;
  int           n_chg;
  logic [1:0]   last_st;

  typedef struct {
    bit           k0;
    bit           k1;
    logic [W-1:0] cnt;
    logic [1:0]   exp_state;
    logic [W-1:0] exp_disp;
    int           exp_clr;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    sw.KEY      = key_v;
    sw.tick     = tick_v;
    sw.count_in = cnt_v;
  endtask

  task automatic model_reset();
    key_hist = {2'b11, 2'b11};
    m_st     = S_IDLE;
    m_disp   = '0;
    m_clr    = 1'b0;
    m_p      = 2'b00;
    for (int k = 0; k < 2; k++) begin
      m_lvl[k]   = 1'b1;
      m_armed[k] = 1'b0;
      m_fell[k]  = 1'b0;
      m_run[k]   = 0;
      m_diff[k]  = 0;
    end
  endtask

  // Advance the model across one rising edge.
  task automatic model_edge();
    logic [1:0] s;
    logic [1:0] pn;
    logic [1:0] prev;
    logic       active;
    logic       en_now;
    logic       sat;
    logic       clr_now;
    prev    = m_st;
    clr_now = m_clr;
    active  = (prev == S_RUN) || (prev == S_LAP);
    en_now  = tick_v && active && (cnt_v != 16'hFFFF);
    sat     = tick_v && active && (cnt_v == 16'hFFFF);
    m_clr   = 1'b0;
    case (prev)
      S_IDLE: if (m_p[0]) m_st = S_RUN;
      S_RUN:  if (m_p[0] || sat) m_st = S_STOP; else if (m_p[1]) m_st = S_LAP;
      S_LAP:  if (m_p[0] || sat) m_st = S_STOP; else if (m_p[1]) m_st = S_RUN;
      default: begin
        if (m_p[0]) m_st = S_RUN;
        else if (m_p[1]) begin
          m_st  = S_IDLE;
          m_clr = 1'b1;
        end
      end
    endcase
    if (prev != S_LAP) m_disp = cnt_v;
    // The board counter: clear wins, otherwise count on enable.
    if (clr_now) cnt_v = '0;
    else if (en_now) cnt_v = cnt_v + 16'd1;
    // Key front end: the debouncer sees the key level from two cycles back.
    key_hist.push_back(key_v);
    s = key_hist.pop_front();
    for (int k = 0; k < 2; k++) begin
      pn[k]     = m_fell[k] && m_armed[k];
      m_fell[k] = 1'b0;
      if (!m_armed[k]) begin
        if (s[k] && m_lvl[k]) m_run[k]++;
        else m_run[k] = 0;
        if (m_run[k] == N) m_armed[k] = 1'b1;
      end
      if (s[k] != m_lvl[k]) begin
        m_diff[k]++;
        if (m_diff[k] == N) begin
          m_lvl[k]  = s[k];
          m_diff[k] = 0;
          m_fell[k] = !s[k];
        end
      end else begin
        m_diff[k] = 0;
      end
    end
    m_p = pn;
  endtask

  // One clock cycle: drive, compare on the falling edge, advance the model.
  task automatic step();
    logic exp_en;
    drive();
    @(negedge clk);
    exp_en = tick_v && ((m_st == S_RUN) || (m_st == S_LAP)) && (cnt_v != 16'hFFFF);
    check("state", 32'(sw.state), 32'(m_st));
    check("disp",  32'(sw.disp),  32'(m_disp));
    check("clr",   32'(sw.clr),   32'(m_clr));
    check("en",    32'(sw.en),    32'(exp_en));
    if (sw.clr) clr_seen++;
    if (sw.clr && sw.en) clr_en++;
    if (sw.state != last_st) n_chg++;
    last_st = sw.state;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_obs();
    clr_seen = 0;
    clr_en   = 0;
    n_chg    = 0;
  endtask

  // Hold the selected keys low for 10 cycles, then release for 10.
  task automatic press(input bit k0, input bit k1);
    key_v = {~k1, ~k0};
    steps(10);
    key_v = 2'b11;
    steps(10);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_state", 32'(sw.state), 32'(S_IDLE));
    check("rst_disp",  32'(sw.disp),  32'h0);
    check("rst_clr",   32'(sw.clr),   32'h0);
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst     = 1'b0;
    last_st = S_IDLE;
    clear_obs();
  endtask

  initial begin
    logic [W-1:0] prev_cnt;
    rst = 1'b1;
    drive();

    tbl[0]  = '{k0: 1'b0, k1: 1'b1, cnt: 16'h0000, exp_state: S_IDLE, exp_disp: 16'h0000, exp_clr: 0};
    tbl[1]  = '{k0: 1'b1, k1: 1'b0, cnt: 16'h0010, exp_state: S_RUN,  exp_disp: 16'h0010, exp_clr: 0};
    tbl[2]  = '{k0: 1'b0, k1: 1'b1, cnt: 16'h0020, exp_state: S_LAP,  exp_disp: 16'h0020, exp_clr: 0};
    tbl[3]  = '{k0: 1'b0, k1: 1'b1, cnt: 16'h0030, exp_state: S_RUN,  exp_disp: 16'h0030, exp_clr: 0};
    tbl[4]  = '{k0: 1'b0, k1: 1'b1, cnt: 16'h0040, exp_state: S_LAP,  exp_disp: 16'h0040, exp_clr: 0};
    tbl[5]  = '{k0: 1'b1, k1: 1'b0, cnt: 16'h0050, exp_state: S_STOP, exp_disp: 16'h0050, exp_clr: 0};
    tbl[6]  = '{k0: 1'b1, k1: 1'b0, cnt: 16'h0060, exp_state: S_RUN,  exp_disp: 16'h0060, exp_clr: 0};
    tbl[7]  = '{k0: 1'b1, k1: 1'b0, cnt: 16'h0070, exp_state: S_STOP, exp_disp: 16'h0070, exp_clr: 0};
    tbl[8]  = '{k0: 1'b0, k1: 1'b1, cnt: 16'h0080, exp_state: S_IDLE, exp_disp: 16'h0000, exp_clr: 1};
    tbl[9]  = '{k0: 1'b0, k1: 1'b1, cnt: 16'h0090, exp_state: S_IDLE, exp_disp: 16'h0090, exp_clr: 0};
    tbl[10] = '{k0: 1'b1, k1: 1'b1, cnt: 16'h00A0, exp_state: S_RUN,  exp_disp: 16'h00A0, exp_clr: 0};
    tbl[11] = '{k0: 1'b1, k1: 1'b1, cnt: 16'h00B0, exp_state: S_STOP, exp_disp: 16'h00B0, exp_clr: 0};

    // Clean start press: RUN appears 8 edges after the key edge; en follows tick.
    do_reset();
    steps(10);
    key_v[0] = 1'b0;
    steps(7);
    check("t1_idle_before", 32'(sw.state), 32'(S_IDLE));
    steps(1);
    check("t1_run_at_8", 32'(sw.state), 32'(S_RUN));
    steps(2);
    key_v = 2'b11;
    steps(10);
    tick_v = 1'b1;
    drive();
    #1;
    check("t1_en_tick", 32'(sw.en), 32'h1);
    steps(3);
    tick_v = 1'b0;
    drive();
    #1;
    check("t1_en_notick", 32'(sw.en), 32'h0);
    steps(2);

    // Table of key actions from a fresh reset
    do_reset();
    steps(10);
    foreach (tbl[i]) begin
      cnt_v = tbl[i].cnt;
      clear_obs();
      press(tbl[i].k0, tbl[i].k1);
      check($sformatf("tbl%0d_state", i), 32'(sw.state), 32'(tbl[i].exp_state));
      check($sformatf("tbl%0d_disp", i),  32'(sw.disp),  32'(tbl[i].exp_disp));
      check($sformatf("tbl%0d_clr", i),   32'(clr_seen), 32'(tbl[i].exp_clr));
    end

    // Bounce shorter than the window, then a steady press: one transition.
    do_reset();
    steps(10);
    for (int i = 0; i < 6; i++) begin
      key_v[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      steps(2);
    end
    key_v[0] = 1'b0;
    steps(12);
    key_v = 2'b11;
    steps(12);
    check("t2_one_change", 32'(n_chg), 32'd1);
    check("t2_state", 32'(sw.state), 32'(S_RUN));

    // Lap freeze while the counter advances, then unfreeze.
    cnt_v = 16'h0123;
    press(1'b0, 1'b1);
    check("t3_lap", 32'(sw.state), 32'(S_LAP));
    check("t3_latched", 32'(sw.disp), 32'h0123);
    tick_v = 1'b1;
    steps(5);
    check("t3_held", 32'(sw.disp), 32'h0123);
    check("t3_count_moved", 32'(cnt_v), 32'h0128);
    tick_v = 1'b0;
    press(1'b0, 1'b1);
    check("t3_run", 32'(sw.state), 32'(S_RUN));
    tick_v   = 1'b1;
    prev_cnt = cnt_v;
    step();
    check("t3_track", 32'(sw.disp), 32'(prev_cnt));
    tick_v = 1'b0;

    // STOP then clear: one clr pulse with en low; clear again in IDLE does nothing.
    tick_v = 1'b1;
    press(1'b1, 1'b0);
    check("t4_stop", 32'(sw.state), 32'(S_STOP));
    clear_obs();
    press(1'b0, 1'b1);
    check("t4_idle", 32'(sw.state), 32'(S_IDLE));
    check("t4_clr_once", 32'(clr_seen), 32'd1);
    check("t4_clr_en", 32'(clr_en), 32'd0);
    clear_obs();
    press(1'b0, 1'b1);
    check("t4_idle_again", 32'(sw.state), 32'(S_IDLE));
    check("t4_no_clr", 32'(clr_seen), 32'd0);
    tick_v = 1'b0;

    // Simultaneous presses and counter saturation.
    press(1'b1, 1'b0);
    check("t5_run", 32'(sw.state), 32'(S_RUN));
    press(1'b1, 1'b1);
    check("t5_both_stop", 32'(sw.state), 32'(S_STOP));
    cnt_v = 16'hFFFF;
    press(1'b1, 1'b0);
    check("t5_run_max", 32'(sw.state), 32'(S_RUN));
    tick_v = 1'b1;
    drive();
    #1;
    check("t5_sat_en", 32'(sw.en), 32'h0);
    step();
    check("t5_sat_stop", 32'(sw.state), 32'(S_STOP));
    tick_v = 1'b0;
    step();
    check("t5_disp_max", 32'(sw.disp), 32'hFFFF);

    // Reset in LAP with a key held through reset release.
    cnt_v = 16'h0042;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("t6_lap", 32'(sw.state), 32'(S_LAP));
    key_v[0] = 1'b0;
    steps(3);
    do_reset();
    check("t6_disp0", 32'(sw.disp), 32'h0);
    steps(20);
    check("t6_no_press", 32'(n_chg), 32'd0);
    check("t6_idle", 32'(sw.state), 32'(S_IDLE));
    key_v = 2'b11;
    steps(15);
    press(1'b1, 1'b0);
    check("t6_repress", 32'(sw.state), 32'(S_RUN));

    // Random keys, ticks and occasional near-full counts against the model.
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 7) == 0) key_v[k] = ~key_v[k];
      end
      tick_v = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) cnt_v = 16'hFFF8 + 16'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
